stream_checker: RTL and testbench
=================================

STREAM_CHECKER -- requirements
Module: stream_checker

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the data width.
REQ-002 The module SHALL have parameter CNT_W, default 16, giving the counter and word-count width.
REQ-003 The module SHALL have parameter TIMEOUT, default 1024, giving the number of consecutive idle cycles that aborts a run.
REQ-004 Port clkout  input  1  is the single clock; all logic SHALL be on its rising edge.
REQ-005 Port rstout  input  1  is a synchronous, active-high reset.
REQ-006 Port start  input  1  is a one-cycle run request.
REQ-007 Port num_words  input  CNT_W  is the number of words to consume per run, sampled at start.
REQ-008 Port seed  input  DATA_W  is the first expected data value, sampled at start.
REQ-009 Port stall_period  input  4  is the number of cycles oready is held low after each accepted word, sampled at start.
REQ-010 Port ovalid  input  1  is the upstream data-valid signal.
REQ-011 Port dout  input  DATA_W  is the upstream data.
REQ-012 Port oready  output  1  is the sink-ready signal.
REQ-013 Port busy  output  1  is high while a run is in progress.
REQ-014 Port done  output  1  is high when a run has ended, and stays high until the next start.
REQ-015 Port pass  output  1  is high when a run has ended with no errors and no timeout.
REQ-016 Port timeout  output  1  is high when the run ended by watchdog.
REQ-017 Port read_count  output  CNT_W  is the number of words accepted in the current or last run.
REQ-018 Port error_count  output  CNT_W  is the number of mismatches, saturating at all-ones.
REQ-019 Port first_err_idx  output  CNT_W  is the read_count value at the first mismatch.
REQ-020 Port first_err_data  output  DATA_W  is the dout value at the first mismatch.

Function
REQ-021 A transfer SHALL occur exactly on a rising clkout edge where ovalid=1 and oready=1.
REQ-022 The FSM SHALL have states IDLE, ACCEPT, GAP and DONE; outputs SHALL be registered and Moore-style.
REQ-023 In IDLE or DONE, start=1 SHALL clear all counters and error captures, latch num_words, seed and stall_period, load expected=seed, and go to ACCEPT; if num_words=0 it SHALL go to DONE with pass=1 instead.
REQ-024 oready SHALL be 1 only in ACCEPT, asserted the cycle after start is sampled; busy SHALL be 1 in ACCEPT and GAP.
REQ-025 On each transfer, dout SHALL be compared with expected; expected SHALL then increment modulo 2^DATA_W (0xFF wraps to 0x00), and read_count SHALL increment.
REQ-026 On a mismatch, error_count SHALL increment (saturating); on the first mismatch only, first_err_idx and first_err_data SHALL be captured.
REQ-027 After a transfer, if read_count+1 equals num_words the FSM SHALL go to DONE; otherwise it SHALL go to GAP when stall_period>0, or stay in ACCEPT.
REQ-028 GAP SHALL last exactly stall_period cycles with oready=0 and then return to ACCEPT; ovalid SHALL be ignored during GAP.
REQ-029 The idle counter SHALL count consecutive ACCEPT cycles with ovalid=0 and clear on any transfer; when it reaches TIMEOUT the FSM SHALL go to DONE with timeout=1.
REQ-030 done SHALL rise the cycle after the final transfer or the timeout; pass SHALL equal (error_count==0 && !timeout) while done=1, and SHALL be 0 otherwise.
REQ-031 start SHALL be ignored in ACCEPT and GAP.
REQ-032 Outputs SHALL hold their final values in DONE until the next start.

Reset
REQ-033 rstout=1 SHALL force IDLE and set oready, busy, done, pass and timeout to 0, and all counts and captures to 0, overriding start on the same edge.
REQ-034 Reset asserted mid-run SHALL abort the run with no transfer on that edge; the checker SHALL then require a new start.

Verification
REQ-035 Feed seed=0x01, num_words=3, stall_period=0, with ovalid constantly high and data 01,02,03 -> oready high 3 cycles; done the cycle after the 3rd transfer; read_count=3; pass=1.
REQ-036 Run with num_words=8, stall_period=2 -> oready pattern 1,0,0 repeating; 8 transfers; pass=1; no transfer during GAP even with ovalid=1.
REQ-037 Feed seed=0xFE, num_words=4 with data FE,FF,00,02 -> error_count=1, first_err_idx=3, first_err_data=0x02, pass=0.
REQ-038 Run with TIMEOUT=16, num_words=5, and only 2 words supplied -> timeout=1, done=1, read_count=2, pass=0.
REQ-039 Assert rstout mid-run after 2 transfers -> all outputs 0 next cycle; a new start with num_words=0 -> done=1 and pass=1 one cycle later.
REQ-040 Assert start during ACCEPT -> no effect on counters or latched parameters.

Source files
------------

// File: rtl/stream_checker.sv
// rtl/stream_checker.sv - sink that checks an incrementing data stream with gap pacing and a watchdog
module stream_checker #(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clkout,
    input  logic              rstout,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [DATA_W-1:0] seed,
    input  logic [3:0]        stall_period,
    input  logic              ovalid,
    input  logic [DATA_W-1:0] dout,
    output logic              oready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  read_count,
    output logic [CNT_W-1:0]  error_count,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_data
);

    // Idle counter must be able to reach TIMEOUT; the run aborts on its last idle cycle.
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCEPT, GAP, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    words_q;
    logic [3:0]          stall_q;
    logic [3:0]          gap_cnt;
    logic [DATA_W-1:0]   expected;
    logic [IDLE_W-1:0]   idle_cnt;

    logic [CNT_W-1:0]    count_inc;
    logic [CNT_W-1:0]    err_inc;
    logic                mismatch;

    // Next-value helpers for the transfer path; error count saturates at all-ones.
    always_comb begin
        count_inc = read_count + 1'b1;
        err_inc   = (&error_count) ? error_count : error_count + 1'b1;
        mismatch  = (dout != expected);
    end

    // Run sequencing, data checking and all registered outputs.
    always_ff @(posedge clkout) begin
        if (rstout) begin
            state          <= IDLE;
            oready         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            read_count     <= '0;
            error_count    <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            words_q        <= '0;
            stall_q        <= '0;
            gap_cnt        <= '0;
            expected       <= '0;
            idle_cnt       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        read_count     <= '0;
                        error_count    <= '0;
                        first_err_idx  <= '0;
                        first_err_data <= '0;
                        timeout        <= 1'b0;
                        idle_cnt       <= '0;
                        gap_cnt        <= '0;
                        words_q        <= num_words;
                        stall_q        <= stall_period;
                        expected       <= seed;
                        if (num_words == '0) begin
                            state  <= DONE;
                            oready <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            pass   <= 1'b1;
                        end else begin
                            state  <= ACCEPT;
                            oready <= 1'b1;
                            busy   <= 1'b1;
                            done   <= 1'b0;
                            pass   <= 1'b0;
                        end
                    end
                end
                ACCEPT: begin
                    if (ovalid && oready) begin
                        expected   <= expected + 1'b1;
                        read_count <= count_inc;
                        idle_cnt   <= '0;
                        if (mismatch) begin
                            error_count <= err_inc;
                            if (error_count == '0) begin
                                first_err_idx  <= read_count;
                                first_err_data <= dout;
                            end
                        end
                        if (count_inc == words_q) begin
                            state  <= DONE;
                            oready <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            pass   <= (error_count == '0) && !mismatch;
                        end else if (stall_q != 4'd0) begin
                            state   <= GAP;
                            gap_cnt <= stall_q;
                            oready  <= 1'b0;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        state   <= DONE;
                        oready  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd1) begin
                        state  <= ACCEPT;
                        oready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_checker.sv
// tb/tb_stream_checker.sv - randomized self-checking bench for stream_checker
module tb_stream_checker;

    localparam int DATA_W  = 8;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 16;

    logic              clkout = 1'b0;
    logic              rstout;
    logic              start;
    logic [CNT_W-1:0]  num_words;
    logic [DATA_W-1:0] seed;
    logic [3:0]        stall_period;
    logic              ovalid;
    logic [DATA_W-1:0] dout;
    logic              oready;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [CNT_W-1:0]  read_count;
    logic [CNT_W-1:0]  error_count;
    logic [CNT_W-1:0]  first_err_idx;
    logic [DATA_W-1:0] first_err_data;

    int n_checks = 0;
    int n_fail   = 0;

    stream_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clkout(clkout), .rstout(rstout), .start(start), .num_words(num_words),
        .seed(seed), .stall_period(stall_period), .ovalid(ovalid), .dout(dout),
        .oready(oready), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .read_count(read_count), .error_count(error_count),
        .first_err_idx(first_err_idx), .first_err_data(first_err_data)
    );

    always #5 clkout = ~clkout;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clkout);
        @(negedge clkout);
    endtask

    // One run: the model tracks accepted words, ready pacing and idle time from the rules alone.
    task automatic do_run(input logic [7:0] s, input int n, input int st, input int vpct,
                          input int epct, input int supply, input int bad_idx,
                          input logic [7:0] bad_val, input bit noise);
        int acc = 0, since = 99, idle = 0, errs = 0, f_idx = 0, cyc = 0;
        logic [7:0] f_data = 8'h00;
        logic [7:0] exp_d;
        bit fin, to_exp, exp_ready, xfer;
        fin = (n == 0);
        to_exp = 1'b0;
        start = 1'b1; num_words = CNT_W'(n); seed = s; stall_period = 4'(st);
        ovalid = 1'b0;
        next_cycle();
        while (!fin && cyc < 3000) begin
            cyc++;
            exp_ready = (since >= st);
            expect_eq("run_oready", oready, exp_ready);
            expect_eq("run_busy", busy, 1);
            expect_eq("run_done", done, 0);
            expect_eq("run_read_count", read_count, acc);
            expect_eq("run_error_count", error_count, errs);
            if (noise && $urandom_range(0, 9) == 0) begin
                start = 1'b1;
                num_words = CNT_W'($urandom_range(0, 50));
                seed = 8'($urandom);
                stall_period = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            exp_d = s + 8'(acc);
            ovalid = (acc < supply) && ($urandom_range(1, 100) <= vpct);
            dout = ovalid ? exp_d : 8'($urandom);
            if (ovalid && acc == bad_idx) dout = bad_val;
            else if (ovalid && $urandom_range(1, 100) <= epct) dout = exp_d ^ 8'($urandom_range(1, 255));
            xfer = ovalid && exp_ready;
            if (xfer) begin
                if (dout != exp_d) begin
                    if (errs == 0) begin
                        f_idx = acc;
                        f_data = dout;
                    end
                    errs++;
                end
                acc++;
                since = 0;
                idle = 0;
                if (acc == n) fin = 1'b1;
            end else begin
                if (since < 99) since++;
                if (exp_ready) begin
                    idle++;
                    if (idle == TIMEOUT) begin
                        fin = 1'b1;
                        to_exp = 1'b1;
                    end
                end
            end
            next_cycle();
        end
        start = 1'b0;
        if (!fin) expect_eq("run_bound", 0, 1);
        for (int h = 0; h < 3; h++) begin
            expect_eq("end_done", done, 1);
            expect_eq("end_busy", busy, 0);
            expect_eq("end_oready", oready, 0);
            expect_eq("end_timeout", timeout, to_exp);
            expect_eq("end_pass", pass, (errs == 0) && !to_exp);
            expect_eq("end_read_count", read_count, acc);
            expect_eq("end_error_count", error_count, errs);
            expect_eq("end_first_err_idx", first_err_idx, f_idx);
            expect_eq("end_first_err_data", first_err_data, f_data);
            ovalid = 1'(h & 1);
            dout = 8'($urandom);
            next_cycle();
        end
        ovalid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        expect_eq({tag, "_oready"}, oready, 0);
        expect_eq({tag, "_busy"}, busy, 0);
        expect_eq({tag, "_done"}, done, 0);
        expect_eq({tag, "_pass"}, pass, 0);
        expect_eq({tag, "_timeout"}, timeout, 0);
        expect_eq({tag, "_read_count"}, read_count, 0);
        expect_eq({tag, "_error_count"}, error_count, 0);
        expect_eq({tag, "_first_err_idx"}, first_err_idx, 0);
        expect_eq({tag, "_first_err_data"}, first_err_data, 0);
    endtask

    initial begin
        rstout = 1'b1; start = 1'b1; num_words = 16'd5; seed = 8'h10;
        stall_period = 4'd0; ovalid = 1'b0; dout = 8'h00;
        @(negedge clkout);
        next_cycle();
        check_all_zero("reset");
        rstout = 1'b0; start = 1'b0;
        next_cycle();
        check_all_zero("idle");

        do_run(8'h01, 3, 0, 100, 0, 1000, -1, 8'h00, 1'b0);
        do_run(8'($urandom), 8, 2, 100, 0, 1000, -1, 8'h00, 1'b0);
        do_run(8'hFE, 4, 0, 100, 0, 1000, 3, 8'h02, 1'b0);
        do_run(8'h30, 5, 0, 100, 0, 2, -1, 8'h00, 1'b0);

        for (int r = 0; r < 12; r++)
            do_run(8'($urandom), $urandom_range(1, 12), $urandom_range(0, 3),
                   70, 15, 1000, -1, 8'h00, 1'b1);

        // Reset in the middle of a run, then a zero-length run.
        start = 1'b1; num_words = 16'd5; seed = 8'h40; stall_period = 4'd0;
        next_cycle();
        start = 1'b0; ovalid = 1'b1; dout = 8'h40;
        next_cycle();
        dout = 8'h41;
        next_cycle();
        expect_eq("mid_read_count", read_count, 2);
        dout = 8'h42; rstout = 1'b1;
        next_cycle();
        check_all_zero("midreset");
        rstout = 1'b0;
        next_cycle();
        next_cycle();
        expect_eq("post_reset_oready", oready, 0);
        expect_eq("post_reset_read_count", read_count, 0);
        ovalid = 1'b0;
        start = 1'b1; num_words = 16'd0;
        next_cycle();
        start = 1'b0;
        expect_eq("zero_done", done, 1);
        expect_eq("zero_pass", pass, 1);
        expect_eq("zero_busy", busy, 0);
        expect_eq("zero_read_count", read_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
